// File: rtl/mdu_scheduler.sv
// Multiply/divide unit with HI/LO for the E stage: fixed-latency MULT/DIV, MT*/MF* access, D-stage stall.
// Latency: MULT_CYCLES/DIV_CYCLES busy cycles, then HI/LO update; MF* combinational; MT* one edge.
// Backpressure: no handshake; stall holds MDU instructions in D while busy or an arith op starts.
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        D_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] read_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MTHI = 3'd6;
    localparam logic [2:0] OP_MTLO = 3'd7;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   pend_q;
    logic          pend_vld_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    logic          is_arith;
    logic          is_div;
    logic          is_signed;
    logic [63:0]   mul_a;
    logic [63:0]   mul_b;
    logic [63:0]   prod;
    logic          a_neg;
    logic          b_neg;
    logic          div_zero;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [31:0]   quo_u;
    logic [31:0]   rem_u;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic [63:0]   pend_d;
    logic          pend_vld_d;

    assign is_arith  = ~op[2];
    assign is_div    = op[1];
    assign is_signed = ~op[0];

    // The result is computed from the operands presented at the start edge,
    // so the pending register doubles as the operand latch.
    always_comb begin
        mul_a    = is_signed ? {{32{operand_a[31]}}, operand_a} : {32'd0, operand_a};
        mul_b    = is_signed ? {{32{operand_b[31]}}, operand_b} : {32'd0, operand_b};
        prod     = mul_a * mul_b;

        a_neg    = is_signed & operand_a[31];
        b_neg    = is_signed & operand_b[31];
        div_zero = (operand_b == 32'd0);
        abs_a    = a_neg ? (32'd0 - operand_a) : operand_a;
        abs_b    = b_neg ? (32'd0 - operand_b) : operand_b;
        quo_u    = div_zero ? 32'd0 : (abs_a / abs_b);
        rem_u    = div_zero ? 32'd0 : (abs_a % abs_b);
        // 0x80000000 / -1 falls out naturally: |a|=0x80000000, negation wraps back.
        quo      = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
        rem      = a_neg ? (32'd0 - rem_u) : rem_u;

        pend_d     = is_div ? {rem, quo} : prod;
        pend_vld_d = ~(is_div & div_zero);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_arith) begin
                            pend_q     <= pend_d;
                            pend_vld_q <= pend_vld_d;
                            cnt_q      <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state_q    <= S_BUSY;
                        end else if (op == OP_MTHI) begin
                            hi_q <= operand_a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= operand_a;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CW'(1)) begin
                        if (pend_vld_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                        pend_vld_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy  = (state_q == S_BUSY);
    assign stall = D_md_use & (busy | (start & is_arith));
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        read_data = 32'd0;
        if (op == OP_MFHI) begin
            read_data = hi_q;
        end else if (op == OP_MFLO) begin
            read_data = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Scoreboard bench for mdu_scheduler: stimulus pushes expected busy length and HI/LO,
// a negedge monitor compares when busy drops.
module tb_mdu_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        D_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } sb_t;

    sb_t sb_q[$];

    mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .D_md_use  (D_md_use),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo),
        .read_data (read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input int cyc, input logic [31:0] h, input logic [31:0] l);
        sb_t e;
        e.name = name;
        e.cyc  = cyc;
        e.hi   = h;
        e.lo   = l;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; inputs are sampled at the next edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles, required 0", name, n);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: counts busy cycles and checks HI/LO whenever busy falls.
    initial begin : monitor
        logic prev_busy;
        int   cnt;
        sb_t  e;
        prev_busy = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                cnt++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got busy drop after %0d cycles, required none", cnt);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_busy_cycles"}, 32'(cnt), 32'(e.cyc));
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                end
                cnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        op        = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        D_md_use  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // MULT -3 * 5 with a dependent MDU instruction waiting in D
        push("mult_neg", 5, 32'hffffffff, 32'hfffffff1);
        D_md_use  = 1'b1;
        start     = 1'b1;
        op        = 3'd0;
        operand_a = 32'hfffffffd;
        operand_b = 32'd5;
        #1;
        chk("stall_start_cycle", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy_cycle", {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        chk("stall_after_commit", {31'd0, stall}, 32'd0);
        D_md_use = 1'b0;
        wait_done("mult_neg");

        // MULTU, independent D instruction never stalled
        push("multu", 5, 32'h00000001, 32'hfffffffe);
        issue(3'd1, 32'hffffffff, 32'd2);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("no_stall_independent", {31'd0, stall}, 32'd0);
        wait_done("multu");

        push("div_neg", 10, 32'hffffffff, 32'hfffffffd);
        issue(3'd2, 32'hfffffff9, 32'd2);
        wait_done("div_neg");

        push("divu", 10, 32'h00000001, 32'h00000003);
        issue(3'd3, 32'd7, 32'd2);
        wait_done("divu");

        issue(3'd6, 32'h00001234, 32'd0);
        chk("mthi_hi", hi, 32'h00001234);
        chk("mthi_lo_kept", lo, 32'h00000003);
        chk("mthi_no_busy", {31'd0, busy}, 32'd0);

        push("divu_zero", 10, 32'h00001234, 32'h00000003);
        issue(3'd3, 32'd9, 32'd0);
        wait_done("divu_zero");

        push("div_ovf", 10, 32'h00000000, 32'h80000000);
        issue(3'd2, 32'h80000000, 32'hffffffff);
        wait_done("div_ovf");

        issue(3'd7, 32'h0000abcd, 32'd0);
        chk("mtlo_lo", lo, 32'h0000abcd);
        start = 1'b1;
        op    = 3'd5;
        #1;
        chk("mflo_read", read_data, 32'h0000abcd);
        op = 3'd4;
        #1;
        chk("mfhi_read", read_data, 32'h00000000);
        start = 1'b0;
        op    = 3'd6;
        #1;
        chk("read_other_zero", read_data, 32'h00000000);

        // Starts during busy must be ignored: counter and result unchanged
        push("divu_ignore", 10, 32'd2, 32'd14);
        issue(3'd3, 32'd100, 32'd7);
        @(posedge clk); #1;
        issue(3'd0, 32'd5, 32'd5);
        issue(3'd6, 32'h0000dead, 32'd0);
        chk("ignored_mthi_hi", hi, 32'h00000000);
        wait_done("divu_ignore");

        // Reset in the 3rd busy cycle of a DIV
        push("div_reset", 3, 32'd0, 32'd0);
        issue(3'd2, 32'd1000, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("reset_mid_busy", {31'd0, busy}, 32'd0);
        chk("reset_mid_hi", hi, 32'd0);
        chk("reset_mid_lo", lo, 32'd0);
        wait_done("div_reset");

        push("mult_after_reset", 5, 32'd1, 32'd0);
        issue(3'd0, 32'h00010000, 32'h00010000);
        wait_done("mult_after_reset");

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
